// File: rtl/bram_arb_pkg.sv
// Shared types and limits for the round-robin BRAM port arbiter.
package bram_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side and backend-side strobe/done bus of the BRAM arbiter.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_read;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         req_rdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_wdata;
  logic                      bram_read;
  logic                      bram_write;
  logic [DATA_W-1:0]         bram_rdata;
  logic                      bram_done;

  // slave: the arbiter; master: requesters plus the BRAM backend around it
  modport slave (
    input  req_read, req_write, req_addr, req_wdata, bram_rdata, bram_done,
    output req_rdata, req_done, bram_addr, bram_wdata, bram_read, bram_write
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, bram_rdata, bram_done,
    input  req_rdata, req_done, bram_addr, bram_wdata, bram_read, bram_write
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active index after last_grant, with wrap.
module rr_pick #(
  parameter  int NUM_REQ = 2,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [GW-1:0]      last_grant,
  output logic               valid,
  output logic [GW-1:0]      grant
);

  logic [NUM_REQ-1:0] rotated;

  always_comb begin
    int start;
    int sel;
    start   = (int'(last_grant) + 1) % NUM_REQ;
    rotated = NUM_REQ'({active, active} >> start);
    valid   = 1'b0;
    sel     = 0;
    // descending scan leaves the lowest set bit of the rotated vector
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        valid = 1'b1;
        sel   = j;
      end
    end
    grant = GW'((sel + start) % NUM_REQ);
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-ported BRAM between NUM_REQ strobe/done requesters, round-robin.
//
// state   | meaning
// IDLE    | strobes low; arbitrate and latch the winner's request
// BUSY    | strobe held on the backend until bram_done
// RELEASE | dead cycle carrying req_done/req_rdata, grantee drops request
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic                clk,
  input logic                res_n,
  bram_port_arbiter_if.slave bus
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("bram_port_arbiter: NUM_REQ must be in 2..%0d", MAX_REQ);
  end

  state_t             state_q, state_nxt;
  op_t                op_q, op_nxt;
  logic [GW-1:0]      grant_q, grant_nxt;
  logic [GW-1:0]      last_q, last_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [DATA_W-1:0]  wdata_q, wdata_nxt;
  logic               read_q, read_nxt;
  logic               write_q, write_nxt;
  logic [DATA_W-1:0]  rdata_q, rdata_nxt;
  logic [NUM_REQ-1:0] done_q, done_nxt;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] pick_mask;
  logic               pick_valid;
  logic [GW-1:0]      pick_grant;
  logic               pick_is_write;

  assign active        = bus.req_read | bus.req_write;
  assign pick_mask     = NUM_REQ'(1) << pick_grant;
  assign pick_is_write = |(bus.req_write & pick_mask);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .active     (active),
    .last_grant (last_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      read_q  <= read_nxt;
      write_q <= write_nxt;
      rdata_q <= rdata_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    op_nxt    = op_q;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    rdata_nxt = rdata_q;
    done_nxt  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick_grant;
          last_nxt  = pick_grant;
          // write wins when a requester raises both strobes
          op_nxt    = pick_is_write ? OP_WRITE : OP_READ;
          addr_nxt  = ADDR_W'(bus.req_addr >> (int'(pick_grant) * ADDR_W));
          wdata_nxt = DATA_W'(bus.req_wdata >> (int'(pick_grant) * DATA_W));
          read_nxt  = !pick_is_write;
          write_nxt = pick_is_write;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.bram_done) begin
          if (op_q == OP_READ) begin
            rdata_nxt = bus.bram_rdata;
          end
          done_nxt  = NUM_REQ'(1) << grant_q;
          state_nxt = RELEASE;
        end else begin
          read_nxt  = (op_q == OP_READ);
          write_nxt = (op_q == OP_WRITE);
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.bram_read  = read_q;
  assign bus.bram_write = write_q;
  assign bus.req_rdata  = rdata_q;
  assign bus.req_done   = done_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: vector table, scoreboard queue, corner sequences.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          idx;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          lat;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  int          model_last;
  logic [31:0] model_rdata;
  logic [N-1:0] prev_done = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_model(input logic [N-1:0] act, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (act[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_req(input int idx, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_read[idx]            = rd;
    bus.req_write[idx]           = wr;
    bus.req_addr[idx*AW +: AW]   = addr;
    bus.req_wdata[idx*DW +: DW]  = wdata;
  endtask

  task automatic push_exp(input int idx, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] brdata);
    exp_t e;
    if (!wr) model_rdata = brdata;
    e.idx = idx; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.brdata = brdata; e.rdata = model_rdata;
    sb.push_back(e);
    model_last = idx;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    bus.req_read = '0;
    bus.req_write = '0;
    bus.bram_done = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
    model_last = N - 1;
    model_rdata = '0;
    sb.delete();
  endtask

  // drop_at: 0 = grantee drops in RELEASE, -1 = keeps requesting, k>0 = drops in k-th busy cycle
  task automatic serve(input int lat, input int drop_at, input int exp_wait);
    int   n;
    exp_t e;
    n = 0;
    while (!(bus.bram_read || bus.bram_write) && n < 20) begin
      tick();
      n++;
    end
    if (!(bus.bram_read || bus.bram_write)) begin
      check("strobe_timeout", 0, 1);
      return;
    end
    if (exp_wait >= 0) check("grant_latency", n, exp_wait);
    if (sb.size() == 0) begin
      check("unexpected_grant", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("bram_write", bus.bram_write, e.wr);
    check("bram_read", bus.bram_read, !e.wr);
    check("bram_addr", bus.bram_addr, e.addr);
    check("bram_wdata", bus.bram_wdata, e.wdata);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1)
        check("strobe_held", {bus.bram_read, bus.bram_write, bus.bram_addr},
              {!e.wr, e.wr, e.addr});
      if (k == drop_at) begin
        bus.req_read[e.idx]          = 1'b0;
        bus.req_write[e.idx]         = 1'b0;
        bus.req_addr[e.idx*AW +: AW] = 32'hF0F0_0000;
      end
      if (k == lat) begin
        bus.bram_done  = 1'b1;
        bus.bram_rdata = e.brdata;
      end
      tick();
    end
    bus.bram_done  = 1'b0;
    bus.bram_rdata = $urandom;
    check("strobe_drop", {bus.bram_read, bus.bram_write}, 2'b00);
    check("req_done", bus.req_done, N'(1) << e.idx);
    check("req_rdata", bus.req_rdata, e.rdata);
    if (drop_at == 0) begin
      bus.req_read[e.idx]  = 1'b0;
      bus.req_write[e.idx] = 1'b0;
    end
    tick();
    check("done_one_cycle", bus.req_done, '0);
    check("release_strobes", {bus.bram_read, bus.bram_write}, 2'b00);
  endtask

  always @(negedge clk) begin
    if (bus.req_done != '0) begin
      checks++;
      if ($countones(bus.req_done) != 1 || prev_done != '0) begin
        errors++;
        $display("FAIL done_onehot_spacing: got %0h prev %0h expected one isolated bit",
                 bus.req_done, prev_done);
      end
    end
    prev_done = bus.req_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] act;
    int           p;

    bus.req_read   = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.bram_rdata = '0;
    bus.bram_done  = 1'b0;

    res_n = 1'b0;
    tick();
    tick();
    check("rst_bram_read", bus.bram_read, 0);
    check("rst_bram_write", bus.bram_write, 0);
    check("rst_bram_addr", bus.bram_addr, 0);
    check("rst_bram_wdata", bus.bram_wdata, 0);
    check("rst_req_rdata", bus.req_rdata, 0);
    check("rst_req_done", bus.req_done, 0);
    do_reset();

    // single-requester vectors: plain read, read+write conflict, long/short backend latency
    vecs[0] = '{0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 3};
    vecs[1] = '{1, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_0001, 32'h9999_9999, 1};
    vecs[2] = '{2, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0005, 32'h1234_5678, 1};
    vecs[3] = '{3, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h6666_6666, 2};
    vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 4};
    vecs[5] = '{0, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0000, 32'h55AA_55AA, 1};
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i].idx, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      push_exp(vecs[i].idx, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].brdata);
      serve(vecs[i].lat, 0, 1);
    end

    // simultaneous: req0 write, req1 read at the same edge
    do_reset();
    drive_req(0, 1'b0, 1'b1, 32'h0000_0200, 32'h1122_3344);
    drive_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000);
    act = bus.req_read | bus.req_write;
    for (int k = 0; k < 2; k++) begin
      p = rr_model(act, model_last);
      act[p] = 1'b0;
      if (p == 0) push_exp(0, 1'b1, 32'h0000_0200, 32'h1122_3344, 32'hEEEE_EEEE);
      else        push_exp(1, 1'b0, 32'h0000_0300, 32'h0000_0000, 32'h7777_8888);
    end
    serve(1, 0, 1);
    serve(1, 0, 1);

    // fairness: all four requesters held active
    do_reset();
    for (int i = 0; i < N; i++) drive_req(i, 1'b1, 1'b0, 32'h1000_0000 + i * 16, 32'h0);
    for (int n = 0; n < 8; n++) begin
      p = rr_model(bus.req_read | bus.req_write, model_last);
      push_exp(p, 1'b0, 32'h1000_0000 + p * 16, 32'h0, 32'h0000_1000 + n);
      serve(1, -1, 1);
    end
    bus.req_read = '0;
    tick();
    tick();

    // grantee drops its request mid-BUSY; next grant moves on to req3
    do_reset();
    drive_req(2, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    drive_req(3, 1'b1, 1'b0, 32'h0000_0084, 32'h0);
    act = bus.req_read | bus.req_write;
    for (int k = 0; k < 2; k++) begin
      p = rr_model(act, model_last);
      act[p] = 1'b0;
      push_exp(p, 1'b0, (p == 2) ? 32'h0000_0080 : 32'h0000_0084, 32'h0,
               (p == 2) ? 32'h2222_0002 : 32'h3333_0003);
    end
    serve(3, 1, 1);
    serve(1, 0, 1);

    // reset in the middle of a BUSY write, then a stray bram_done
    do_reset();
    drive_req(1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_1234);
    tick();
    check("busy_before_reset", bus.bram_write, 1);
    tick();
    res_n = 1'b0;
    bus.req_write[1] = 1'b0;
    tick();
    check("mid_rst_strobes", {bus.bram_read, bus.bram_write}, 2'b00);
    check("mid_rst_addr", bus.bram_addr, 0);
    check("mid_rst_wdata", bus.bram_wdata, 0);
    check("mid_rst_rdata", bus.req_rdata, 0);
    check("mid_rst_done", bus.req_done, 0);
    res_n = 1'b1;
    model_last = N - 1;
    model_rdata = '0;
    bus.bram_done = 1'b1;
    bus.bram_rdata = 32'hFFFF_FFFF;
    tick();
    bus.bram_done = 1'b0;
    check("stray_done_ignored", bus.req_done, 0);
    check("stray_done_strobes", {bus.bram_read, bus.bram_write}, 2'b00);
    tick();
    check("stray_done_ignored2", bus.req_done, 0);
    check("stray_done_rdata", bus.req_rdata, 0);
    drive_req(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
    push_exp(0, 1'b0, 32'h0000_0600, 32'h0, 32'h6060_6060);
    serve(1, 0, 1);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
